// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared halfword width, RVC detection and fetch-align output record
package riscv_core_pkg;
  localparam int HW_W = 16;
  localparam int FA_XLEN = 64;
  typedef struct packed {
    logic [31:0]        instr;
    logic [FA_XLEN-1:0] pc;
    logic               compressed;
  } fetch_align_out_t;
  function automatic logic is_rvc(input logic [HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/riscv_core_fetch_align_buffer.sv
// riscv_core_fetch_align_buffer: halfword queue turning aligned fetch words into one 32/16-bit instruction per cycle with pc and compressed flag
module riscv_core_fetch_align_buffer
  import riscv_core_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int BUF_HW = 4
) (
  input  logic            i_fetch_align_clk,
  input  logic            i_fetch_align_rst,
  input  logic            i_fetch_align_flush,
  input  logic [31:0]     i_fetch_align_data,
  input  logic [XLEN-1:0] i_fetch_align_pc,
  input  logic            i_fetch_align_valid,
  output logic            o_fetch_align_ready,
  output logic [31:0]     o_fetch_align_instr,
  output logic [XLEN-1:0] o_fetch_align_instr_pc,
  output logic            o_fetch_align_compressed,
  output logic            o_fetch_align_valid,
  input  logic            i_fetch_align_ready
);
  localparam int CW = $clog2(BUF_HW + 1);
  logic [CW-1:0]   count, need, pop_hw, push_hw, base;
  logic [XLEN-1:0] head_pc, seq_pc;
  logic [HW_W-1:0] hq [BUF_HW];
  logic [HW_W-1:0] nq [BUF_HW];
  logic [HW_W-1:0] hx [BUF_HW+2];
  logic [HW_W-1:0] first_hw;
  logic            head_rvc, push, pop, seq_valid;
  assign head_rvc = is_rvc(hq[0]);
  assign need = head_rvc ? CW'(1) : CW'(2);
  assign o_fetch_align_valid = count >= need;
  assign o_fetch_align_ready = count <= CW'(BUF_HW - 2);
  assign push = i_fetch_align_valid & o_fetch_align_ready;
  assign pop = o_fetch_align_valid & i_fetch_align_ready;
  assign pop_hw = pop ? need : '0;
  assign push_hw = push ? (i_fetch_align_pc[1] ? CW'(1) : CW'(2)) : '0;
  assign base = count - pop_hw;
  assign first_hw = i_fetch_align_pc[1] ? i_fetch_align_data[31:16] : i_fetch_align_data[15:0];
  assign o_fetch_align_instr = head_rvc ? {16'h0, hq[0]} : {hq[1], hq[0]};
  assign o_fetch_align_instr_pc = head_pc;
  // An empty queue holds zeros, which would otherwise read as compressed
  assign o_fetch_align_compressed = head_rvc & (count != '0);
  assign hx[BUF_HW] = '0;
  assign hx[BUF_HW+1] = '0;
  // Pop shifts the queue down, push halfwords land right behind what remains
  for (genvar i = 0; i < BUF_HW; i++) begin : g_q
    logic [HW_W-1:0] sh;
    assign hx[i] = hq[i];
    assign sh = pop_hw == CW'(2) ? hx[i+2] : pop_hw == CW'(1) ? hx[i+1] : hx[i];
    assign nq[i] = push && base == CW'(i) ? first_hw :
                   push && !i_fetch_align_pc[1] && base + CW'(1) == CW'(i) ? i_fetch_align_data[31:16] : sh;
  end
  always_ff @(posedge i_fetch_align_clk or posedge i_fetch_align_rst) begin
    if (i_fetch_align_rst) begin
      count <= '0;
      head_pc <= '0;
      for (int i = 0; i < BUF_HW; i++) hq[i] <= '0;
    end else if (i_fetch_align_flush) begin
      count <= '0;
    end else begin
      count <= base + push_hw;
      for (int i = 0; i < BUF_HW; i++) hq[i] <= nq[i];
      if (push && base == '0) head_pc <= {i_fetch_align_pc[XLEN-1:1], 1'b0};
      else if (pop) head_pc <= head_pc + (head_rvc ? XLEN'(2) : XLEN'(4));
    end
  end
  // Tracks the pc the next sequential fetch word must carry
  always_ff @(posedge i_fetch_align_clk or posedge i_fetch_align_rst) begin
    if (i_fetch_align_rst) begin
      seq_valid <= 1'b0;
      seq_pc <= '0;
    end else if (i_fetch_align_flush) begin
      seq_valid <= 1'b0;
    end else if (push) begin
      seq_valid <= 1'b1;
      seq_pc <= {i_fetch_align_pc[XLEN-1:2], 2'b00} + XLEN'(4);
    end
  end
  a_seq_pc: assert property (@(posedge i_fetch_align_clk) disable iff (i_fetch_align_rst)
    push && !i_fetch_align_flush && seq_valid |-> i_fetch_align_pc == seq_pc);
  a_pc_bit0: assert property (@(posedge i_fetch_align_clk) disable iff (i_fetch_align_rst)
    push |-> !i_fetch_align_pc[0]);
endmodule

// File: tb/tb_riscv_core_fetch_align_buffer.sv
// tb_riscv_core_fetch_align_buffer: scoreboard bench for the fetch align buffer
module tb_riscv_core_fetch_align_buffer;
  import riscv_core_pkg::*;
  logic        clk = 0, rst = 0, flush = 0, in_valid = 0, dec_ready = 0;
  logic [31:0] data = '0;
  logic [63:0] pc = '0;
  logic        in_ready, out_valid, cmp;
  logic [31:0] instr;
  logic [63:0] ipc;
  int checks = 0, errors = 0;
  fetch_align_out_t sb[$];
  fetch_align_out_t e, held;
  logic stalled = 0;
  riscv_core_fetch_align_buffer #(.XLEN(64), .BUF_HW(4)) dut (
    .i_fetch_align_clk(clk),
    .i_fetch_align_rst(rst),
    .i_fetch_align_flush(flush),
    .i_fetch_align_data(data),
    .i_fetch_align_pc(pc),
    .i_fetch_align_valid(in_valid),
    .o_fetch_align_ready(in_ready),
    .o_fetch_align_instr(instr),
    .o_fetch_align_instr_pc(ipc),
    .o_fetch_align_compressed(cmp),
    .o_fetch_align_valid(out_valid),
    .i_fetch_align_ready(dec_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [31:0] d, input logic [63:0] a);
    int n = 0;
    in_valid = 1;
    data = d;
    pc = a;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", in_ready, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic exp_instr(input logic [31:0] i, input logic [63:0] p, input logic c);
    sb.push_back({i, p, c});
  endtask
  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!rst && !flush && out_valid) begin
      if (dec_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %h at pc %h, required none", instr, ipc);
        end else begin
          e = sb.pop_front();
          check("instr", instr, e.instr);
          check("instr_pc", ipc, e.pc);
          check("compressed", cmp, e.compressed);
        end
        stalled <= 0;
      end else begin
        if (stalled) begin
          check("stall_instr", instr, held.instr);
          check("stall_pc", ipc, held.pc);
          check("stall_cmp", cmp, held.compressed);
        end
        stalled <= 1;
        held <= {instr, ipc, cmp};
      end
    end else stalled <= 0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] w [3];
    logic        rexp [5];
    int idx;
    logic took;
    w = '{32'h11051101, 32'h110D1109, 32'h11151111};
    rexp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    #1 rst = 1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_instr", instr, 0);
    check("rst_pc", ipc, 0);
    check("rst_cmp", cmp, 0);
    tick();
    tick();
    rst = 0;
    check("rel_valid", out_valid, 0);
    check("rel_ready", in_ready, 1);
    dec_ready = 1;
    exp_instr(32'h00500093, 64'h1000, 0);
    exp_instr(32'h00A00113, 64'h1004, 0);
    check("t32_ready0", in_ready, 1);
    push_word(32'h00500093, 64'h1000);
    check("t32_ready1", in_ready, 1);
    push_word(32'h00A00113, 64'h1004);
    check("t32_ready2", in_ready, 1);
    wait_drain();
    do_flush();
    exp_instr(32'h00004505, 64'h2000, 1);
    exp_instr(32'h000040A1, 64'h2002, 1);
    push_word(32'h40A14505, 64'h2000);
    wait_drain();
    do_flush();
    exp_instr(32'h00004505, 64'h3000, 1);
    push_word(32'h00934505, 64'h3000);
    tick();
    check("strad_wait0", out_valid, 0);
    tick();
    tick();
    check("strad_wait1", out_valid, 0);
    exp_instr(32'h00500093, 64'h3002, 0);
    exp_instr(32'h00001234, 64'h3006, 1);
    push_word(32'h12340050, 64'h3004);
    wait_drain();
    do_flush();
    dec_ready = 0;
    push_word(32'h45050000, 64'h5002);
    push_word(32'h40A14505, 64'h5004);
    check("rd_valid_pre", out_valid, 1);
    check("rd_ready_pre", in_ready, 0);
    dec_ready = 1;
    flush = 1;
    tick();
    flush = 0;
    check("rd_valid_post", out_valid, 0);
    exp_instr(32'h00004505, 64'h4002, 1);
    push_word(32'h4505ABCD, 64'h4002);
    wait_drain();
    do_flush();
    dec_ready = 0;
    for (int k = 0; k < 6; k++) exp_instr({16'h0, 16'h1101 + 16'(4 * k)}, 64'h6000 + 64'(2 * k), 1);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1;
      data = w[idx];
      pc = 64'h6000 + 64'(4 * idx);
      check("bp_ready", in_ready, rexp[c]);
      took = in_ready;
      tick();
      if (took) idx++;
    end
    check("bp_valid", out_valid, 1);
    check("bp_idx", idx, 2);
    dec_ready = 1;
    push_word(w[2], 64'h6008);
    wait_drain();
    do_flush();
    dec_ready = 0;
    push_word(32'h45050000, 64'h7002);
    push_word(32'h40A14505, 64'h7004);
    check("mr_ready_pre", in_ready, 0);
    #2 rst = 1;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_ready", in_ready, 1);
    check("mr_instr", instr, 0);
    tick();
    rst = 0;
    check("mr_rel_valid", out_valid, 0);
    check("mr_rel_ready", in_ready, 1);
    dec_ready = 1;
    exp_instr(32'h00004505, 64'h8000, 1);
    exp_instr(32'h000040A1, 64'h8002, 1);
    push_word(32'h40A14505, 64'h8000);
    wait_drain();
    tick();
    tick();
    check("idle_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
